// File: rtl/dsp_xaddr_router.sv
// AW/AR address router: base/mask decode, one-entry request slice, order FIFO and beat steering.
// Optional macro DSP_XADDR_DECERR_EN: unmapped requests become decode-error entries instead of going to slave 0.
module dsp_xaddr_router #(
  parameter int unsigned SLV_AMT           = 4,
  parameter int unsigned OUTSTANDING_AMT   = 8,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_MST_ID_W    = 5,
  parameter int unsigned TRANS_BURST_W     = 2,
  parameter int unsigned TRANS_DATA_LEN_W  = 8,
  parameter int unsigned TRANS_DATA_SIZE_W = 3,
  parameter logic [ADDR_WIDTH*SLV_AMT-1:0] SLV_BASE = '0,
  parameter logic [ADDR_WIDTH*SLV_AMT-1:0] SLV_MASK = '0,
  parameter int unsigned SLV_ID_W          = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [TRANS_MST_ID_W-1:0]             m_AxID_i,
  input  logic [ADDR_WIDTH-1:0]                 m_AxADDR_i,
  input  logic [TRANS_BURST_W-1:0]              m_AxBURST_i,
  input  logic [TRANS_DATA_LEN_W-1:0]           m_AxLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0]          m_AxSIZE_i,
  input  logic                                  m_AxVALID_i,
  output logic                                  m_AxREADY_o,
  output logic [TRANS_MST_ID_W*SLV_AMT-1:0]     sa_AxID_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]         sa_AxADDR_o,
  output logic [TRANS_BURST_W*SLV_AMT-1:0]      sa_AxBURST_o,
  output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]   sa_AxLEN_o,
  output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]  sa_AxSIZE_o,
  output logic [SLV_AMT-1:0]                    sa_AxVALID_o,
  input  logic [SLV_AMT-1:0]                    sa_AxREADY_i,
  output logic [SLV_AMT-1:0]                    sa_Ax_outst_full_o,
  input  logic                                  m_xVALID_i,
  input  logic                                  m_xREADY_i,
  output logic [SLV_ID_W-1:0]                   dsp_xDATA_slv_id_o,
  output logic                                  dsp_xDATA_disable_o,
  output logic                                  dsp_xDATA_last_o,
  output logic                                  dsp_xDATA_decerr_o,
  output logic [SLV_ID_W-1:0]                   dsp_WRESP_slv_id_o,
  output logic                                  dsp_WRESP_shift_en_o,
  output logic [$clog2(OUTSTANDING_AMT):0]      outst_cnt_o
);

  localparam int unsigned PTR_W = $clog2(OUTSTANDING_AMT);

  logic [SLV_ID_W-1:0]          dec_id;
  logic                         dec_hit;
  logic                         slice_vld;
  logic                         slice_hs;
  logic                         slice_decerr;
  logic [SLV_ID_W-1:0]          slice_id;
  logic [TRANS_MST_ID_W-1:0]    slice_axid;
  logic [ADDR_WIDTH-1:0]        slice_addr;
  logic [TRANS_BURST_W-1:0]     slice_burst;
  logic [TRANS_DATA_LEN_W-1:0]  slice_len;
  logic [TRANS_DATA_SIZE_W-1:0] slice_size;

  logic [SLV_ID_W-1:0]          id_mem  [OUTSTANDING_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  len_mem [OUTSTANDING_AMT];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W:0]               count;
  logic [TRANS_DATA_LEN_W-1:0]  beat_cnt;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         push;
  logic                         beat_hs;
  logic                         last_beat;
  logic                         pop;

  // Ascending scan with a found flag keeps the lowest matching index.
  always_comb begin
    dec_hit = 1'b0;
    dec_id  = '0;
    for (int unsigned i = 0; i < SLV_AMT; i++) begin
      if (!dec_hit &&
          ((m_AxADDR_i & SLV_MASK[ADDR_WIDTH*i +: ADDR_WIDTH]) == SLV_BASE[ADDR_WIDTH*i +: ADDR_WIDTH])) begin
        dec_hit = 1'b1;
        dec_id  = SLV_ID_W'(i);
      end
    end
  end

  assign fifo_full   = (count == (PTR_W+1)'(OUTSTANDING_AMT));
  assign fifo_empty  = (count == '0);
  assign slice_hs    = slice_vld & (slice_decerr | sa_AxREADY_i[slice_id]);
  assign m_AxREADY_o = ~fifo_full & (~slice_vld | slice_hs);
  assign push        = m_AxVALID_i & m_AxREADY_o;
  assign beat_hs     = m_xVALID_i & m_xREADY_i & ~fifo_empty;
  assign last_beat   = ~fifo_empty & (beat_cnt == len_mem[rd_ptr]);
  assign pop         = beat_hs & last_beat;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      slice_vld <= 1'b0;
    end else if (push) begin
      slice_vld <= 1'b1;
    end else if (slice_hs) begin
      slice_vld <= 1'b0;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (push) begin
      slice_id    <= dec_id;
      slice_axid  <= m_AxID_i;
      slice_addr  <= m_AxADDR_i;
      slice_burst <= m_AxBURST_i;
      slice_len   <= m_AxLEN_i;
      slice_size  <= m_AxSIZE_i;
      id_mem[wr_ptr]  <= dec_id;
      len_mem[wr_ptr] <= m_AxLEN_i;
    end
  end

`ifdef DSP_XADDR_DECERR_EN
  logic err_mem [OUTSTANDING_AMT];

  // Unmapped requests still occupy the slice for one cycle, then self-drain.
  always_ff @(posedge ACLK_i) begin
    if (push) begin
      slice_decerr    <= ~dec_hit;
      err_mem[wr_ptr] <= ~dec_hit;
    end
  end

  assign dsp_xDATA_decerr_o = ~fifo_empty & err_mem[rd_ptr];
`else
  assign slice_decerr       = 1'b0;
  assign dsp_xDATA_decerr_o = 1'b0;
`endif

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (pop)          beat_cnt <= '0;
      else if (beat_hs) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_comb begin
    sa_AxVALID_o = '0;
    for (int unsigned i = 0; i < SLV_AMT; i++) begin
      sa_AxVALID_o[i] = slice_vld & (slice_id == SLV_ID_W'(i)) & ~slice_decerr;
    end
  end

  assign sa_AxID_o          = {SLV_AMT{slice_axid}};
  assign sa_AxADDR_o        = {SLV_AMT{slice_addr}};
  assign sa_AxBURST_o       = {SLV_AMT{slice_burst}};
  assign sa_AxLEN_o         = {SLV_AMT{slice_len}};
  assign sa_AxSIZE_o        = {SLV_AMT{slice_size}};
  assign sa_Ax_outst_full_o = {SLV_AMT{fifo_full}};

  assign dsp_xDATA_slv_id_o   = fifo_empty ? '0 : id_mem[rd_ptr];
  assign dsp_WRESP_slv_id_o   = dsp_xDATA_slv_id_o;
  assign dsp_xDATA_disable_o  = fifo_empty;
  assign dsp_xDATA_last_o     = last_beat;
  assign dsp_WRESP_shift_en_o = pop;
  assign outst_cnt_o          = count;

endmodule

// File: tb/tb_dsp_xaddr_router.sv
// Directed bench for dsp_xaddr_router (4 slaves on the top two address bits, slave 3 narrowed).
module tb_dsp_xaddr_router;

  localparam logic [127:0] BASE = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hF000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   m_id = '0;
  logic [31:0]  m_addr = '0;
  logic [1:0]   m_burst = '0;
  logic [7:0]   m_len = '0;
  logic [2:0]   m_size = '0;
  logic         m_valid = 1'b0;
  logic         m_ready;
  logic [19:0]  sa_id;
  logic [127:0] sa_addr;
  logic [7:0]   sa_burst;
  logic [31:0]  sa_len;
  logic [11:0]  sa_size;
  logic [3:0]   sa_valid;
  logic [3:0]   sa_ready = 4'hF;
  logic [3:0]   sa_full;
  logic         x_valid = 1'b0;
  logic         x_ready = 1'b0;
  logic [1:0]   x_slv;
  logic         x_dis;
  logic         x_last;
  logic         x_err;
  logic [1:0]   w_slv;
  logic         w_shift;
  logic [3:0]   cnt;

  int n_cmp = 0;
  int n_err = 0;

  dsp_xaddr_router #(.SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .m_AxID_i(m_id), .m_AxADDR_i(m_addr), .m_AxBURST_i(m_burst), .m_AxLEN_i(m_len),
    .m_AxSIZE_i(m_size), .m_AxVALID_i(m_valid), .m_AxREADY_o(m_ready),
    .sa_AxID_o(sa_id), .sa_AxADDR_o(sa_addr), .sa_AxBURST_o(sa_burst), .sa_AxLEN_o(sa_len),
    .sa_AxSIZE_o(sa_size), .sa_AxVALID_o(sa_valid), .sa_AxREADY_i(sa_ready),
    .sa_Ax_outst_full_o(sa_full), .m_xVALID_i(x_valid), .m_xREADY_i(x_ready),
    .dsp_xDATA_slv_id_o(x_slv), .dsp_xDATA_disable_o(x_dis), .dsp_xDATA_last_o(x_last),
    .dsp_xDATA_decerr_o(x_err), .dsp_WRESP_slv_id_o(w_slv), .dsp_WRESP_shift_en_o(w_shift),
    .outst_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", m_ready); end
    n_cmp++; if (sa_valid !== 4'b0) begin n_err++; $display("FAIL reset_sa_valid got %b want 0000", sa_valid); end
    n_cmp++; if (sa_full !== 4'b0) begin n_err++; $display("FAIL reset_full got %b want 0000", sa_full); end
    n_cmp++; if (x_dis !== 1'b1) begin n_err++; $display("FAIL reset_disable got %b want 1", x_dis); end
    n_cmp++; if (x_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", x_last); end
    n_cmp++; if (x_err !== 1'b0) begin n_err++; $display("FAIL reset_decerr got %b want 0", x_err); end
    n_cmp++; if (w_shift !== 1'b0) begin n_err++; $display("FAIL reset_shift got %b want 0", w_shift); end
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    n_cmp++; if (x_slv !== 2'd0 || w_slv !== 2'd0) begin n_err++; $display("FAIL reset_slv_id got %0d/%0d want 0", x_slv, w_slv); end
  endtask

  task automatic test_single_burst();
    sa_ready = 4'hF;
    m_valid = 1'b1; m_addr = 32'h4000_0010; m_len = 8'd3; m_id = 5'd5; m_burst = 2'd1; m_size = 3'd2;
    #1;
    n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", m_ready); end
    tick();
    m_valid = 1'b0;
    #1;
    n_cmp++; if (sa_valid !== 4'b0010) begin n_err++; $display("FAIL single_sa_valid got %b want 0010", sa_valid); end
    n_cmp++; if (sa_addr[63:32] !== 32'h4000_0010) begin n_err++; $display("FAIL single_addr got %h want 40000010", sa_addr[63:32]); end
    n_cmp++; if (sa_len[15:8] !== 8'd3 || sa_id[9:5] !== 5'd5) begin n_err++; $display("FAIL single_fields got len %0d id %0d want 3 5", sa_len[15:8], sa_id[9:5]); end
    n_cmp++; if (cnt !== 4'd1 || x_dis !== 1'b0) begin n_err++; $display("FAIL single_cnt got %0d dis %b want 1 0", cnt, x_dis); end
    n_cmp++; if (x_slv !== 2'd1 || w_slv !== 2'd1) begin n_err++; $display("FAIL single_slv_id got %0d/%0d want 1", x_slv, w_slv); end
    x_valid = 1'b1; x_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      n_cmp++; if (x_last !== (b == 3)) begin n_err++; $display("FAIL single_last beat %0d got %b want %b", b, x_last, b == 3); end
      n_cmp++; if (w_shift !== (b == 3)) begin n_err++; $display("FAIL single_shift beat %0d got %b want %b", b, w_shift, b == 3); end
      tick();
    end
    x_valid = 1'b0;
    #1;
    n_cmp++; if (x_dis !== 1'b1 || cnt !== 4'd0 || w_shift !== 1'b0) begin n_err++; $display("FAIL single_done got dis %b cnt %0d shift %b want 1 0 0", x_dis, cnt, w_shift); end
  endtask

  task automatic test_fifo_full();
    sa_ready = 4'hF; m_len = 8'd0;
    for (int i = 0; i < 8; i++) begin
      m_valid = 1'b1; m_addr = 32'(i % 4) << 30;
      #1;
      n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL full_fill_ready %0d got %b want 1", i, m_ready); end
      tick();
    end
    m_addr = 32'h0;
    #1;
    n_cmp++; if (m_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", m_ready); end
    n_cmp++; if (cnt !== 4'd8 || sa_full !== 4'hF) begin n_err++; $display("FAIL full_cnt got %0d full %b want 8 1111", cnt, sa_full); end
    tick();
    m_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd8) begin n_err++; $display("FAIL full_no_push got %0d want 8", cnt); end
    n_cmp++; if (sa_valid !== 4'b0) begin n_err++; $display("FAIL full_slice_drain got %b want 0000", sa_valid); end
    x_valid = 1'b1; x_ready = 1'b1;
    #1;
    n_cmp++; if (x_last !== 1'b1 || x_slv !== 2'd0) begin n_err++; $display("FAIL full_pop_head got last %b id %0d want 1 0", x_last, x_slv); end
    tick();
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd7 || m_ready !== 1'b1 || sa_full !== 4'h0) begin n_err++; $display("FAIL full_after_pop got cnt %0d ready %b full %b want 7 1 0000", cnt, m_ready, sa_full); end
    x_valid = 1'b1;
    for (int j = 1; j < 8; j++) begin
      #1;
      n_cmp++; if (x_slv !== 2'(j % 4)) begin n_err++; $display("FAIL full_order %0d got %0d want %0d", j, x_slv, j % 4); end
      tick();
    end
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL full_drained got %0d want 0", cnt); end
  endtask

  task automatic test_stall();
    sa_ready = 4'b1011;
    m_valid = 1'b1; m_addr = 32'h8000_0040; m_id = 5'd7; m_len = 8'd0;
    tick();
    m_addr = 32'h4000_0000; m_id = 5'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (sa_valid !== 4'b0100) begin n_err++; $display("FAIL stall_valid %0d got %b want 0100", k, sa_valid); end
      n_cmp++; if (sa_addr[95:64] !== 32'h8000_0040 || sa_id[14:10] !== 5'd7) begin n_err++; $display("FAIL stall_fields %0d got %h %0d want 80000040 7", k, sa_addr[95:64], sa_id[14:10]); end
      n_cmp++; if (m_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready %0d got %b want 0", k, m_ready); end
      tick();
    end
    sa_ready = 4'hF;
    #1;
    n_cmp++; if (m_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b want 1", m_ready); end
    tick();
    m_valid = 1'b0;
    #1;
    n_cmp++; if (sa_valid !== 4'b0010 || cnt !== 4'd2) begin n_err++; $display("FAIL stall_next got %b cnt %0d want 0010 2", sa_valid, cnt); end
    x_valid = 1'b1; x_ready = 1'b1;
    #1;
    n_cmp++; if (x_slv !== 2'd2) begin n_err++; $display("FAIL stall_head0 got %0d want 2", x_slv); end
    tick();
    #1;
    n_cmp++; if (x_slv !== 2'd1) begin n_err++; $display("FAIL stall_head1 got %0d want 1", x_slv); end
    tick();
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL stall_drained got %0d want 0", cnt); end
  endtask

  task automatic test_back_to_back();
    sa_ready = 4'hF; m_len = 8'd0;
    for (int i = 1; i < 4; i++) begin
      m_valid = 1'b1; m_addr = 32'(i) << 30;
      tick();
    end
    x_valid = 1'b1; x_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_addr = 32'(k) << 30;
      #1;
      n_cmp++; if (cnt !== 4'd3) begin n_err++; $display("FAIL b2b_cnt %0d got %0d want 3", k, cnt); end
      n_cmp++; if (x_slv !== 2'(k + 1) || m_ready !== 1'b1) begin n_err++; $display("FAIL b2b_head %0d got %0d ready %b want %0d 1", k, x_slv, m_ready, k + 1); end
      tick();
    end
    m_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (x_slv !== 2'(k) || cnt !== 4'(3 - k)) begin n_err++; $display("FAIL b2b_drain %0d got id %0d cnt %0d want %0d %0d", k, x_slv, cnt, k, 3 - k); end
      tick();
    end
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL b2b_drained got %0d want 0", cnt); end
  endtask

  task automatic test_unmapped();
    sa_ready = 4'hF;
    m_valid = 1'b1; m_addr = 32'hF000_0000; m_len = 8'd0;
    tick();
    m_valid = 1'b0;
    #1;
`ifdef DSP_XADDR_DECERR_EN
    n_cmp++; if (sa_valid !== 4'b0000) begin n_err++; $display("FAIL unmapped_valid got %b want 0000", sa_valid); end
    n_cmp++; if (x_err !== 1'b1 || x_slv !== 2'd0) begin n_err++; $display("FAIL unmapped_head got err %b id %0d want 1 0", x_err, x_slv); end
`else
    n_cmp++; if (sa_valid !== 4'b0001) begin n_err++; $display("FAIL unmapped_valid got %b want 0001", sa_valid); end
    n_cmp++; if (x_err !== 1'b0 || x_slv !== 2'd0) begin n_err++; $display("FAIL unmapped_head got err %b id %0d want 0 0", x_err, x_slv); end
`endif
    n_cmp++; if (cnt !== 4'd1) begin n_err++; $display("FAIL unmapped_cnt got %0d want 1", cnt); end
    tick();
    n_cmp++; if (sa_valid !== 4'b0 || m_ready !== 1'b1) begin n_err++; $display("FAIL unmapped_drain got %b ready %b want 0000 1", sa_valid, m_ready); end
    x_valid = 1'b1; x_ready = 1'b1;
    #1;
    n_cmp++; if (x_last !== 1'b1) begin n_err++; $display("FAIL unmapped_last got %b want 1", x_last); end
    tick();
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0 || x_err !== 1'b0) begin n_err++; $display("FAIL unmapped_pop got cnt %0d err %b want 0 0", cnt, x_err); end
  endtask

  task automatic test_long_burst();
    m_valid = 1'b1; m_addr = 32'h4000_0000; m_len = 8'd255;
    tick();
    m_valid = 1'b0;
    x_valid = 1'b1; x_ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      #1;
      n_cmp++; if (x_last !== (b == 255)) begin n_err++; $display("FAIL long_last beat %0d got %b want %b", b, x_last, b == 255); end
      tick();
    end
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL long_pop got %0d want 0", cnt); end
  endtask

  task automatic test_reset_mid_burst();
    m_len = 8'd3;
    for (int i = 1; i < 3; i++) begin
      m_valid = 1'b1; m_addr = 32'(i) << 30;
      tick();
    end
    m_valid = 1'b0;
    x_valid = 1'b1; x_ready = 1'b1;
    tick();
    x_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0 || x_dis !== 1'b1) begin n_err++; $display("FAIL rstmid_fifo got cnt %0d dis %b want 0 1", cnt, x_dis); end
    n_cmp++; if (sa_valid !== 4'b0 || m_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_slice got %b ready %b want 0000 1", sa_valid, m_ready); end
    x_valid = 1'b1;
    tick();
    tick();
    x_valid = 1'b0;
    m_valid = 1'b1; m_addr = 32'h8000_0000; m_len = 8'd1;
    tick();
    m_valid = 1'b0;
    #1;
    n_cmp++; if (x_last !== 1'b0 || x_slv !== 2'd2) begin n_err++; $display("FAIL empty_hs_first got last %b id %0d want 0 2", x_last, x_slv); end
    x_valid = 1'b1;
    tick();
    n_cmp++; if (x_last !== 1'b1) begin n_err++; $display("FAIL empty_hs_second got %b want 1", x_last); end
    tick();
    x_valid = 1'b0;
    #1;
    n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL empty_hs_pop got %0d want 0", cnt); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fifo_full();
    test_stall();
    test_back_to_back();
    test_unmapped();
    test_long_burst();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
